// File: rtl/sym_repacker.sv
// Repacks a stream of bytes/nibbles into SYM_W-bit symbols through an MSB-first bit buffer,
// with an explicit drain phase that zero-pads the final partial symbol.
module sym_repacker #(
    parameter int SYM_W    = 5,
    parameter int BUF_BITS = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [7:0]       data_in,
    input  logic             byt,
    input  logic             mod_rdy,
    output logic             full,
    output logic [SYM_W-1:0] dmod,
    output logic             mod_en
);

    localparam int CW = $clog2(BUF_BITS + 1);
    localparam logic [CW-1:0] FULL_AT = CW'(BUF_BITS - 8);
    localparam logic [CW-1:0] SYM_CNT = CW'(SYM_W);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state;
    logic [BUF_BITS-1:0] bits;
    logic [CW-1:0]       cnt;

    logic                push;
    logic                pop;
    logic [CW-1:0]       push_n;
    logic [CW-1:0]       pop_n;
    logic [CW-1:0]       rem;
    logic [7:0]          in_byte;
    logic [BUF_BITS-1:0] kept;
    logic [BUF_BITS-1:0] incoming;

    // Oldest bit sits at bits[BUF_BITS-1]; everything below the valid region is kept at zero,
    // so the top SYM_W bits are already the zero-padded symbol.
    always_comb begin
        full     = (state == DRAIN) || (cnt > FULL_AT);
        mod_en   = (cnt >= SYM_CNT) || ((state == DRAIN) && (cnt != '0));
        dmod     = bits[BUF_BITS-1 -: SYM_W];
        push     = (state != DRAIN) && start && !full;
        pop      = mod_en && mod_rdy;
        pop_n    = '0;
        if (pop) begin
            pop_n = (cnt < SYM_CNT) ? cnt : SYM_CNT;
        end
        push_n   = '0;
        if (push) begin
            push_n = byt ? CW'(8) : CW'(4);
        end
        rem      = cnt - pop_n;
        kept     = bits << pop_n;
        in_byte  = byt ? data_in : {data_in[3:0], 4'b0000};
        incoming = '0;
        if (push) begin
            incoming = {in_byte, {(BUF_BITS-8){1'b0}}} >> rem;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            bits  <= '0;
        end else begin
            bits <= kept | incoming;
            cnt  <= rem + push_n;
            case (state)
                IDLE:    if (start)      state <= RUN;
                RUN:     if (!start)     state <= DRAIN;
                DRAIN:   if (cnt == '0)  state <= IDLE;
                default:                 state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sym_repacker.sv
// Bench for sym_repacker: fixed vectors, hand-written corner sequences and randomized
// traffic compared against a bit-queue reference model.
module tb_sym_repacker;

    localparam int SW  = 5;
    localparam int BB  = 64;
    localparam int BB2 = 16;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n, start, byt, mod_rdy;
    logic [7:0]    data_in;
    logic          full, mod_en;
    logic [SW-1:0] dmod;

    logic          reset_n2, start2, byt2, mod_rdy2;
    logic [7:0]    data_in2;
    logic          full2, mod_en2;
    logic [SW-1:0] dmod2;

    sym_repacker #(.SYM_W(SW), .BUF_BITS(BB)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .data_in(data_in), .byt(byt),
        .mod_rdy(mod_rdy), .full(full), .dmod(dmod), .mod_en(mod_en)
    );

    sym_repacker #(.SYM_W(SW), .BUF_BITS(BB2)) dut16 (
        .clk(clk), .reset_n(reset_n2), .start(start2), .data_in(data_in2), .byt(byt2),
        .mod_rdy(mod_rdy2), .full(full2), .dmod(dmod2), .mod_en(mod_en2)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: a plain queue of bits plus the sequence phase (0 idle, 1 run, 2 drain).
    bit   q[$];
    int   mst = 0;
    logic [SW-1:0] syms[$];
    logic [SW-1:0] syms2[$];

    typedef struct {
        logic       s;
        logic [7:0] d;
        logic       b;
        logic       r;
        logic       en;
        logic [4:0] dm;
        logic       fl;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_full();
        return (mst == 2 || q.size() > BB - 8) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] m_en();
        return (q.size() >= SW || (mst == 2 && q.size() > 0)) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] m_dmod();
        logic [31:0] v = 0;
        for (int i = 0; i < SW; i++) v = (v << 1) | ((i < q.size()) ? 32'(q[i]) : 32'd0);
        return v;
    endfunction

    task automatic mdl_edge(input logic s, input logic [7:0] d, input logic b,
                            input logic r, input logic rn);
        int f, e, n, sz0;
        f   = int'(m_full());
        e   = int'(m_en());
        sz0 = q.size();
        if (!rn) begin
            q.delete();
            mst = 0;
            return;
        end
        if (e != 0 && r) begin
            n = (q.size() < SW) ? q.size() : SW;
            repeat (n) void'(q.pop_front());
        end
        if (mst != 2 && s && f == 0) begin
            if (b) for (int i = 7; i >= 0; i--) q.push_back(d[i]);
            else   for (int i = 3; i >= 0; i--) q.push_back(d[i]);
        end
        case (mst)
            0: if (s) mst = 1;
            1: if (!s) mst = 2;
            default: if (sz0 == 0) mst = 0;
        endcase
    endtask

    // Called at a falling edge; drives one rising edge and returns at the next falling edge.
    task automatic cyc(input logic s, input logic [7:0] d, input logic b,
                       input logic r, input logic rn);
        start = s; data_in = d; byt = b; mod_rdy = r; reset_n = rn;
        if (rn && mod_en && r) syms.push_back(dmod);
        @(posedge clk);
        mdl_edge(s, d, b, r, rn);
        @(negedge clk);
        chk("full", 32'(full), m_full());
        chk("mod_en", 32'(mod_en), m_en());
        if (m_en() != 0 || (mst == 0 && q.size() == 0)) chk("dmod", 32'(dmod), m_dmod());
    endtask

    task automatic cyc2(input logic s, input logic [7:0] d, input logic r, input logic rn);
        start2 = s; data_in2 = d; byt2 = 1'b1; mod_rdy2 = r; reset_n2 = rn;
        if (rn && mod_en2 && r) syms2.push_back(dmod2);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain_rand();
        int guard = 0;
        while ((mst != 0 || q.size() != 0) && guard < 200) begin
            cyc(1'b0, 8'($urandom), 1'($urandom), ($urandom % 3) != 0, 1'b1);
            guard++;
        end
        chk("drain_bound", 32'(guard < 200), 32'd1);
    endtask

    task automatic chk_syms(input string nm, input logic [SW-1:0] exp[$]);
        chk({nm, "_count"}, 32'(syms.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < syms.size(); i++)
            chk(nm, 32'(syms[i]), 32'(exp[i]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]    seq_d [6] = '{8'h10, 8'h02, 8'h43, 8'h95, 8'h06, 8'h87};
        logic          seq_b [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic          rpat  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [SW-1:0] exp29 [$] = '{5'h02, 5'h00, 5'h12, 5'h03, 5'h12, 5'h15, 5'h14, 5'h07};
        int            en_cycles;
        int            k;
        logic          r, en0;
        logic [SW-1:0] d0;

        tbl[0] = '{1'b1, 8'h10, 1'b1, 1'b1, 1'b1, 5'h02, 1'b0};
        tbl[1] = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 5'h00, 1'b0};
        tbl[2] = '{1'b1, 8'h43, 1'b1, 1'b1, 1'b1, 5'h12, 1'b0};
        tbl[3] = '{1'b1, 8'h95, 1'b1, 1'b1, 1'b1, 5'h03, 1'b0};
        tbl[4] = '{1'b1, 8'h06, 1'b0, 1'b1, 1'b1, 5'h12, 1'b0};
        tbl[5] = '{1'b1, 8'h87, 1'b1, 1'b1, 1'b1, 5'h15, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 5'h14, 1'b1};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 5'h07, 1'b1};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 5'h00, 1'b1};
        tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 5'h00, 1'b0};

        start = 0; data_in = 0; byt = 0; mod_rdy = 0; reset_n = 0;
        start2 = 0; data_in2 = 0; byt2 = 0; mod_rdy2 = 0; reset_n2 = 0;
        @(negedge clk);

        // Reset with inputs active must leave everything idle.
        cyc(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_mod_en", 32'(mod_en), 32'd0);
        chk("rst_dmod", 32'(dmod), 32'd0);

        // Reference symbol sequence, fixed vectors.
        syms.delete();
        en_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].s, tbl[i].d, tbl[i].b, tbl[i].r, 1'b1);
            chk($sformatf("vec%0d_mod_en", i), 32'(mod_en), 32'(tbl[i].en));
            chk($sformatf("vec%0d_dmod", i), 32'(dmod), 32'(tbl[i].dm));
            chk($sformatf("vec%0d_full", i), 32'(full), 32'(tbl[i].fl));
            if (mod_en) en_cycles++;
        end
        chk("en_cycles", 32'(en_cycles), 32'd8);
        chk_syms("seq29", exp29);

        // Flush of a single byte with a padded last symbol.
        syms.delete();
        cyc(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1);
        chk("flush_dmod0", 32'(dmod), 32'h14);
        cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        chk("flush_en1", 32'(mod_en), 32'd1);
        chk("flush_dmod1", 32'(dmod), 32'h14);
        cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        chk("flush_en_off", 32'(mod_en), 32'd0);
        cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        chk("flush_idle_full", 32'(full), 32'd0);
        chk_syms("flush", '{5'h14, 5'h14});

        // Backpressure: same inputs, stalls inserted; held symbol must not change.
        syms.delete();
        k = 0;
        for (int i = 0; i < 6 || mst != 0; i++) begin
            r   = rpat[k % 4];
            k++;
            en0 = mod_en;
            d0  = dmod;
            if (i < 6) cyc(1'b1, seq_d[i], seq_b[i], r, 1'b1);
            else       cyc(1'b0, 8'h00, 1'b1, r, 1'b1);
            if (en0 && !r) begin
                chk("bp_hold_en", 32'(mod_en), 32'd1);
                chk("bp_hold_dmod", 32'(dmod), 32'(d0));
            end
            if (i > 60) break;
        end
        chk_syms("backpressure", exp29);

        // Reset in the middle of a sequence drops everything.
        for (int i = 0; i < 3; i++) cyc(1'b1, seq_d[i], seq_b[i], 1'b1, 1'b1);
        cyc(1'b1, seq_d[3], seq_b[3], 1'b1, 1'b0);
        chk("midrst_full", 32'(full), 32'd0);
        chk("midrst_mod_en", 32'(mod_en), 32'd0);
        chk("midrst_dmod", 32'(dmod), 32'd0);
        syms.delete();
        cyc(1'b1, 8'hFF, 1'b1, 1'b1, 1'b1);
        drain_rand();
        chk_syms("after_rst", '{5'h1F, 5'h1C});

        // start raised again while draining: input refused until back in idle.
        syms.delete();
        cyc(1'b1, 8'h12, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        chk("drain_full0", 32'(full), 32'd1);
        cyc(1'b1, 8'hCC, 1'b1, 1'b1, 1'b1);
        chk("drain_full1", 32'(full), 32'd1);
        cyc(1'b1, 8'hCC, 1'b1, 1'b1, 1'b1);
        chk("drain_idle_full", 32'(full), 32'd0);
        chk("drain_idle_en", 32'(mod_en), 32'd0);
        cyc(1'b1, 8'hCC, 1'b1, 1'b0, 1'b1);
        chk("restart_en", 32'(mod_en), 32'd1);
        chk("restart_dmod", 32'(dmod), 32'h19);
        drain_rand();

        // Small buffer: third byte refused, drained bits are exactly 0x1122.
        cyc2(1'b0, 8'h00, 1'b0, 1'b0);
        cyc2(1'b1, 8'h11, 1'b0, 1'b1);
        chk("b16_full_after1", 32'(full2), 32'd0);
        cyc2(1'b1, 8'h22, 1'b0, 1'b1);
        chk("b16_full_after2", 32'(full2), 32'd1);
        cyc2(1'b1, 8'h33, 1'b0, 1'b1);
        chk("b16_full_after3", 32'(full2), 32'd1);
        syms2.delete();
        for (int i = 0; i < 12; i++) cyc2(1'b0, 8'h00, 1'b1, 1'b1);
        chk("b16_count", 32'(syms2.size()), 32'd4);
        if (syms2.size() == 4)
            chk("b16_bits", {12'd0, syms2[0], syms2[1], syms2[2], syms2[3]}, 32'h1122 << 4);
        chk("b16_idle_en", 32'(mod_en2), 32'd0);

        // Randomized sequences against the model, with occasional resets.
        for (int s = 0; s < 40; s++) begin
            int nrun = int'($urandom_range(1, 25));
            for (int j = 0; j < nrun; j++)
                cyc(1'b1, 8'($urandom), 1'($urandom), ($urandom % 4) != 0, ($urandom % 50) != 0);
            drain_rand();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
